// File: rtl/rocstar_mcu_link_if.sv
// Rocstar-board end of the rocstar<->MCU serial link.
// Sends one 8-bit symbol per clock: a test pattern, a single-hit time stamp, or idle.
// Decodes one 4-bit symbol per clock from the MCU and keeps link-health counters.
// Every output is registered, so each one follows its input sample by one clock.
module rocstar_mcu_link_if (
  input  logic        clk,
  input  logic        rst,
  input  logic        single,
  input  logic [5:0]  offset,
  input  logic [7:0]  testpatt,
  input  logic        do_testp,
  input  logic [3:0]  from_mcu,
  output logic [7:0]  to_mcu,
  output logic        runmode,
  output logic        sync_clk,
  output logic        save_clk,
  output logic [15:0] spword,
  output logic        pcoinc,
  output logic        dcoinc,
  output logic        ncoinc,
  output logic [15:0] badidle,
  output logic [15:0] numsingl,
  output logic [15:0] numcoinc,
  output logic [7:0]  latency
);

  typedef enum logic [0:0] {StIdle, StSpw} state_e;

  state_e      state_q, state_d;
  logic [1:0]  nib_cnt_q, nib_cnt_d;
  logic [11:0] shift_q, shift_d;

  logic [7:0]  to_mcu_q, to_mcu_d;
  logic        runmode_q, runmode_d;
  logic        sync_q, sync_d;
  logic        save_q, save_d;
  logic [15:0] spword_q, spword_d;
  logic        pcoinc_q, pcoinc_d;
  logic        dcoinc_q, dcoinc_d;
  logic        ncoinc_q, ncoinc_d;
  logic [15:0] badidle_q, badidle_d;
  logic [15:0] numsingl_q, numsingl_d;
  logic [15:0] numcoinc_q, numcoinc_d;
  logic [7:0]  latency_q, latency_d;
  logic [7:0]  timer_q, timer_d;
  logic        pending_q, pending_d;

  logic        sent;
  logic        reply;
  logic [7:0]  timer_inc;

  // Next-state for TX symbol, RX command decoder, counters and latency timer.
  always_comb begin
    state_d    = state_q;
    nib_cnt_d  = nib_cnt_q;
    shift_d    = shift_q;
    runmode_d  = runmode_q;
    spword_d   = spword_q;
    badidle_d  = badidle_q;
    numsingl_d = numsingl_q;
    numcoinc_d = numcoinc_q;
    latency_d  = latency_q;
    timer_d    = timer_q;
    pending_d  = pending_q;
    sync_d     = 1'b0;
    save_d     = 1'b0;
    pcoinc_d   = 1'b0;
    dcoinc_d   = 1'b0;
    ncoinc_d   = 1'b0;
    reply      = 1'b0;

    // Test pattern wins; a single is only sent (and counted) while running.
    sent = ~do_testp & runmode_q & single;
    if (do_testp) begin
      to_mcu_d = testpatt;
    end else if (sent) begin
      to_mcu_d = {2'b10, offset};
    end else begin
      to_mcu_d = 8'h00;
    end
    if (sent) begin
      numsingl_d = numsingl_q + 16'd1;
    end

    unique case (state_q)
      StIdle: begin
        case (from_mcu)
          4'h0: ;
          4'h1: sync_d = 1'b1;
          4'h2: save_d = 1'b1;
          4'h3: runmode_d = 1'b1;
          4'h4: runmode_d = 1'b0;
          4'h5: begin
            state_d   = StSpw;
            nib_cnt_d = 2'd0;
            shift_d   = 12'h000;
          end
          4'h8: begin
            ncoinc_d = 1'b1;
            reply    = 1'b1;
          end
          4'h9: begin
            pcoinc_d   = 1'b1;
            reply      = 1'b1;
            numcoinc_d = numcoinc_q + 16'd1;
          end
          4'hA: begin
            dcoinc_d   = 1'b1;
            reply      = 1'b1;
            numcoinc_d = numcoinc_q + 16'd1;
          end
          default: badidle_d = badidle_q + 16'd1;
        endcase
      end
      StSpw: begin
        // Payload nibbles are data only; nothing here is decoded as a command.
        shift_d   = {shift_q[7:0], from_mcu};
        nib_cnt_d = nib_cnt_q + 2'd1;
        if (nib_cnt_q == 2'd3) begin
          spword_d = {shift_q, from_mcu};
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (sync_d) begin
      numsingl_d = 16'h0000;
      numcoinc_d = 16'h0000;
      badidle_d  = 16'h0000;
    end

    // The timer holds clocks elapsed minus one, so a reply reports timer+1.
    timer_inc = (timer_q == 8'hFF) ? 8'hFF : timer_q + 8'd1;
    if (reply && pending_q) begin
      latency_d = timer_inc;
      pending_d = 1'b0;
    end
    if (sent) begin
      timer_d   = 8'h00;
      pending_d = 1'b1;
    end else if (pending_d) begin
      timer_d = timer_inc;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      nib_cnt_q  <= 2'd0;
      shift_q    <= 12'h000;
      to_mcu_q   <= 8'h00;
      runmode_q  <= 1'b0;
      sync_q     <= 1'b0;
      save_q     <= 1'b0;
      spword_q   <= 16'h0000;
      pcoinc_q   <= 1'b0;
      dcoinc_q   <= 1'b0;
      ncoinc_q   <= 1'b0;
      badidle_q  <= 16'h0000;
      numsingl_q <= 16'h0000;
      numcoinc_q <= 16'h0000;
      latency_q  <= 8'h00;
      timer_q    <= 8'h00;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      nib_cnt_q  <= nib_cnt_d;
      shift_q    <= shift_d;
      to_mcu_q   <= to_mcu_d;
      runmode_q  <= runmode_d;
      sync_q     <= sync_d;
      save_q     <= save_d;
      spword_q   <= spword_d;
      pcoinc_q   <= pcoinc_d;
      dcoinc_q   <= dcoinc_d;
      ncoinc_q   <= ncoinc_d;
      badidle_q  <= badidle_d;
      numsingl_q <= numsingl_d;
      numcoinc_q <= numcoinc_d;
      latency_q  <= latency_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
    end
  end

  assign to_mcu   = to_mcu_q;
  assign runmode  = runmode_q;
  assign sync_clk = sync_q;
  assign save_clk = save_q;
  assign spword   = spword_q;
  assign pcoinc   = pcoinc_q;
  assign dcoinc   = dcoinc_q;
  assign ncoinc   = ncoinc_q;
  assign badidle  = badidle_q;
  assign numsingl = numsingl_q;
  assign numcoinc = numcoinc_q;
  assign latency  = latency_q;

endmodule

// File: tb/tb_rocstar_mcu_link_if.sv
// Bench for rocstar_mcu_link_if: directed scenarios plus random traffic, all
// checked by a queue-based scoreboard fed from a behavioural link model.
module tb_rocstar_mcu_link_if;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        single = 1'b0;
  logic [5:0]  offset = 6'd0;
  logic [7:0]  testpatt = 8'h00;
  logic        do_testp = 1'b0;
  logic [3:0]  from_mcu = 4'h0;
  logic [7:0]  to_mcu;
  logic        runmode, sync_clk, save_clk, pcoinc, dcoinc, ncoinc;
  logic [15:0] spword, badidle, numsingl, numcoinc;
  logic [7:0]  latency;

  rocstar_mcu_link_if dut (
    .clk      (clk),
    .rst      (rst),
    .single   (single),
    .offset   (offset),
    .testpatt (testpatt),
    .do_testp (do_testp),
    .from_mcu (from_mcu),
    .to_mcu   (to_mcu),
    .runmode  (runmode),
    .sync_clk (sync_clk),
    .save_clk (save_clk),
    .spword   (spword),
    .pcoinc   (pcoinc),
    .dcoinc   (dcoinc),
    .ncoinc   (ncoinc),
    .badidle  (badidle),
    .numsingl (numsingl),
    .numcoinc (numcoinc),
    .latency  (latency)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  to;
    logic        run, sync, save;
    logic [15:0] spw;
    logic        p, d, n;
    logic [15:0] bad, ns, nc;
    logic [7:0]  lat;
  } out_t;

  out_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: plain integers, reasoned from the link rules.
  int m_run, m_left, m_acc, m_spw, m_bad, m_ns, m_nc, m_timer, m_pend, m_lat;

  function automatic out_t dut_out();
    return {to_mcu, runmode, sync_clk, save_clk, spword, pcoinc, dcoinc, ncoinc,
            badidle, numsingl, numcoinc, latency};
  endfunction

  task automatic chk(input string name, input logic [85:0] act, input logic [85:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_left = 0; m_acc = 0; m_spw = 0; m_bad = 0;
    m_ns = 0; m_nc = 0; m_timer = 0; m_pend = 0; m_lat = 0;
  endtask

  task automatic model_step();
    out_t e;
    int nib;
    bit sent, reply;
    e = '0;
    reply = 0;
    nib = int'(from_mcu);
    sent = !do_testp && (m_run != 0) && single;
    if (do_testp) e.to = testpatt;
    else if (sent) e.to = 8'(128 + int'(offset));
    else e.to = 8'h00;
    if (m_left > 0) begin
      m_acc = m_acc * 16 + nib;
      m_left--;
      if (m_left == 0) m_spw = m_acc % 65536;
    end else begin
      case (nib)
        0: ;
        1: e.sync = 1'b1;
        2: e.save = 1'b1;
        3: m_run = 1;
        4: m_run = 0;
        5: begin m_left = 4; m_acc = 0; end
        8: begin e.n = 1'b1; reply = 1; end
        9: begin e.p = 1'b1; reply = 1; m_nc = (m_nc + 1) % 65536; end
        10: begin e.d = 1'b1; reply = 1; m_nc = (m_nc + 1) % 65536; end
        default: m_bad = (m_bad + 1) % 65536;
      endcase
    end
    if (sent) m_ns = (m_ns + 1) % 65536;
    if (e.sync) begin m_ns = 0; m_nc = 0; m_bad = 0; end
    // Latency = clocks between the edge sending the single and the edge taking the reply.
    if (reply && m_pend != 0) begin
      m_lat = (m_timer + 1 > 255) ? 255 : m_timer + 1;
      m_pend = 0;
    end
    if (sent) begin
      m_timer = 0;
      m_pend = 1;
    end else if (m_pend != 0) begin
      m_timer = (m_timer + 1 > 255) ? 255 : m_timer + 1;
    end
    e.run = 1'(m_run);
    e.spw = 16'(m_spw);
    e.bad = 16'(m_bad);
    e.ns  = 16'(m_ns);
    e.nc  = 16'(m_nc);
    e.lat = 8'(m_lat);
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs; the model's view of that edge is queued at the edge.
  task automatic step(input bit s, input int off, input int tp, input bit dt, input int fm);
    single = s;
    offset = 6'(off);
    testpatt = 8'(tp);
    do_testp = dt;
    from_mcu = 4'(fm);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    single = 1'b0; offset = 6'd0; testpatt = 8'h00; do_testp = 1'b0; from_mcu = 4'h0;
    model_reset();
    #1;
    chk("reset_outputs", 86'(dut_out()), 86'd0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: every cycle out of reset, pop the model's expectation and compare.
  initial begin
    out_t e, a;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = dut_out();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL scoreboard cyc=%0d got=%h exp=%h", cyc, a, e);
        end
      end
    end
  end

  initial begin
    int r, fm, wait_n;
    int bad_syms[7];
    bad_syms = '{6, 7, 11, 12, 13, 14, 15};
    model_reset();
    do_reset();

    // Run on, then a single with offset 21.
    step(0, 0, 0, 0, 3);
    step(1, 21, 0, 0, 0);
    chk("t1_to_mcu", 86'(to_mcu), 86'h95);
    chk("t1_numsingl", 86'(numsingl), 86'd1);

    // Run off drops singles; test pattern overrides.
    step(0, 0, 0, 0, 4);
    step(1, 7, 0, 0, 0);
    chk("t2_dropped", 86'(to_mcu), 86'h00);
    chk("t2_numsingl", 86'(numsingl), 86'd1);
    step(1, 7, 'hA5, 1, 0);
    chk("t2_testpatt", 86'(to_mcu), 86'hA5);

    // Special word: payload nibbles 1,2,3,4 are not commands.
    step(0, 0, 0, 0, 5);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 2);
    chk("t3_no_save", 86'(save_clk), 86'd0);
    step(0, 0, 0, 0, 3);
    chk("t3_no_run", 86'(runmode), 86'd0);
    step(0, 0, 0, 0, 4);
    chk("t3_spword", 86'(spword), 86'h1234);

    // Prompt reply 12 clocks after the single, then a no-coincidence reply.
    step(0, 0, 0, 0, 3);
    step(1, 3, 0, 0, 0);
    idle(11);
    step(0, 0, 0, 0, 9);
    chk("t4_pcoinc", 86'(pcoinc), 86'd1);
    chk("t4_numcoinc", 86'(numcoinc), 86'd1);
    chk("t4_latency", 86'(latency), 86'd12);
    step(0, 0, 0, 0, 8);
    chk("t4_pcoinc_pulse", 86'(pcoinc), 86'd0);
    chk("t4_ncoinc", 86'(ncoinc), 86'd1);
    chk("t4_numcoinc_hold", 86'(numcoinc), 86'd1);

    // Illegal symbols, then sync clears the counters.
    step(0, 0, 0, 0, 15);
    step(0, 0, 0, 0, 15);
    step(0, 0, 0, 0, 15);
    chk("t5_badidle", 86'(badidle), 86'd3);
    step(0, 0, 0, 0, 1);
    chk("t5_sync", 86'(sync_clk), 86'd1);
    chk("t5_badidle_clr", 86'(badidle), 86'd0);
    chk("t5_numsingl_clr", 86'(numsingl), 86'd0);
    step(0, 0, 0, 0, 0);
    chk("t5_sync_pulse", 86'(sync_clk), 86'd0);

    // Latency saturates.
    step(1, 0, 0, 0, 0);
    idle(300);
    step(0, 0, 0, 0, 10);
    chk("t6_dcoinc", 86'(dcoinc), 86'd1);
    chk("t6_latency", 86'(latency), 86'd255);

    // Reset in the middle of a special word aborts it.
    step(0, 0, 0, 0, 5);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 2);
    do_reset();
    step(0, 0, 0, 0, 3);
    chk("t7_run_after_abort", 86'(runmode), 86'd1);
    step(0, 0, 0, 0, 4);
    chk("t7_spword", 86'(spword), 86'd0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40) fm = 0;
      else if (r < 55) fm = 8 + $urandom_range(0, 2);
      else if (r < 63) fm = 3;
      else if (r < 66) fm = 4;
      else if (r < 72) fm = 5;
      else if (r < 74) fm = 1;
      else if (r < 77) fm = 2;
      else if (r < 81) fm = bad_syms[$urandom_range(0, 6)];
      else fm = $urandom_range(0, 15);
      step($urandom_range(0, 1) == 1, $urandom_range(0, 63), $urandom_range(0, 255),
           $urandom_range(0, 9) == 0, fm);
      if ($urandom_range(0, 49) == 0) idle($urandom_range(1, 40));
    end

    // Drain the scoreboard with a bounded wait.
    wait_n = 0;
    while (exp_q.size() > 0 && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    #1;
    chk("scoreboard_drained", 86'(exp_q.size()), 86'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
